// File: rtl/bridge_req_arbiter_pkg.sv
// Shared types and constants for the two-requester bridge request arbiter.
`timescale 1ns/1ps
`default_nettype none

package bridge_req_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RD_TIMEOUT = 255;
  localparam int DEF_CNT_WIDTH  = 8;

  localparam int NUM_REQ   = 2;
  localparam int REQ_IDX_W = 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Reset value of last_grant; makes rq0 win the first conflict.
  localparam req_idx_t RST_LAST_GRANT = 1'b1;

  typedef enum logic [1:0] {
    ST_ARB     = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_SLEEP   = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bridge_req_arbiter_if.sv
// Requester, bridge and sleep signals of the request arbiter, grouped as one bundle.
`timescale 1ns/1ps
`default_nettype none

interface bridge_req_arbiter_if
  import bridge_req_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  i_sleep_req;
  logic                  o_sleep_ack;
  logic                  o_busy;

  logic                  i_rq0_valid;
  logic                  i_rq0_rd0_wr1;
  logic [ADDR_WIDTH-1:0] i_rq0_addr;
  logic [DATA_WIDTH-1:0] i_rq0_wr_data;
  logic                  o_rq0_ready;
  logic [DATA_WIDTH-1:0] o_rq0_rd_data;
  logic                  o_rq0_rd_valid;
  logic                  o_rq0_rd_err;

  logic                  i_rq1_valid;
  logic                  i_rq1_rd0_wr1;
  logic [ADDR_WIDTH-1:0] i_rq1_addr;
  logic [DATA_WIDTH-1:0] i_rq1_wr_data;
  logic                  o_rq1_ready;
  logic [DATA_WIDTH-1:0] o_rq1_rd_data;
  logic                  o_rq1_rd_valid;
  logic                  o_rq1_rd_err;

  logic                  o_valid;
  logic                  o_rd0_wr1;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  i_rd_valid;

  modport slave (
    input  i_sleep_req,
    output o_sleep_ack, o_busy,
    input  i_rq0_valid, i_rq0_rd0_wr1, i_rq0_addr, i_rq0_wr_data,
    output o_rq0_ready, o_rq0_rd_data, o_rq0_rd_valid, o_rq0_rd_err,
    input  i_rq1_valid, i_rq1_rd0_wr1, i_rq1_addr, i_rq1_wr_data,
    output o_rq1_ready, o_rq1_rd_data, o_rq1_rd_valid, o_rq1_rd_err,
    output o_valid, o_rd0_wr1, o_addr, o_wr_data,
    input  i_ready, i_rd_data, i_rd_valid
  );

  modport master (
    output i_sleep_req,
    input  o_sleep_ack, o_busy,
    output i_rq0_valid, i_rq0_rd0_wr1, i_rq0_addr, i_rq0_wr_data,
    input  o_rq0_ready, o_rq0_rd_data, o_rq0_rd_valid, o_rq0_rd_err,
    output i_rq1_valid, i_rq1_rd0_wr1, i_rq1_addr, i_rq1_wr_data,
    input  o_rq1_ready, o_rq1_rd_data, o_rq1_rd_valid, o_rq1_rd_err,
    input  o_valid, o_rd0_wr1, o_addr, o_wr_data,
    output i_ready, i_rd_data, i_rd_valid
  );

endinterface

`default_nettype wire

// File: rtl/bridge_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a conflict goes to the one not granted last.
`timescale 1ns/1ps
`default_nettype none

module rr_arb2
  import bridge_req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  output req_idx_t   sel,
  output logic       any
);

  always_comb begin
    any = req[0] | req[1];
    sel = 1'b0;
    unique case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter sharing the bridge source slave port between two requesters,
// with a single outstanding read, read timeout and a sleep handshake.
`timescale 1ns/1ps
`default_nettype none

module bridge_req_arbiter
  import bridge_req_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic               i_clk_src,
  input  logic               i_rstn_src,
  bridge_req_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(RD_TIMEOUT);

  state_t                 state;
  state_t                 next_state;
  req_idx_t               last_grant;
  req_idx_t               rd_owner;
  req_idx_t               sel;
  logic                   any;
  logic                   arb_open;
  logic                   sel_valid;
  logic                   sel_rd;
  logic                   xfer;
  logic                   timeout_hit;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_dir;
  logic [CNT_WIDTH-1:0]   rd_cnt;
  logic [NUM_REQ-1:0]     rd_valid_q;
  logic [NUM_REQ-1:0]     rd_err_q;
  logic [DATA_WIDTH-1:0]  rd_data_q [NUM_REQ];

  rr_arb2 u_rr_arb2 (
    .req        ({bus.i_rq1_valid, bus.i_rq0_valid}),
    .last_grant (last_grant),
    .sel        (sel),
    .any        (any)
  );

  // Sleep request blocks selection in the same cycle it is seen in ARB.
  always_comb begin
    arb_open  = (state == ST_ARB) && !bus.i_sleep_req;
    sel_valid = arb_open && any;
    sel_dir   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (sel_valid) begin
      if (sel == 1'b0) begin
        sel_dir   = bus.i_rq0_rd0_wr1;
        sel_addr  = bus.i_rq0_addr;
        sel_wdata = bus.i_rq0_wr_data;
      end else begin
        sel_dir   = bus.i_rq1_rd0_wr1;
        sel_addr  = bus.i_rq1_addr;
        sel_wdata = bus.i_rq1_wr_data;
      end
    end
    sel_rd      = sel_valid && !sel_dir;
    xfer        = sel_valid && bus.i_ready;
    timeout_hit = (RD_TIMEOUT != 0) && (rd_cnt == TIMEOUT_VAL);
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_ARB: begin
        if (bus.i_sleep_req)   next_state = ST_SLEEP;
        else if (xfer && sel_rd) next_state = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.i_rd_valid || timeout_hit) next_state = ST_ARB;
      end
      ST_SLEEP: begin
        if (!bus.i_sleep_req) next_state = ST_ARB;
      end
      default: next_state = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      state      <= ST_ARB;
      last_grant <= RST_LAST_GRANT;
      rd_owner   <= '0;
      rd_cnt     <= '0;
    end else begin
      state <= next_state;
      if (xfer) last_grant <= sel;
      if (state == ST_ARB && xfer && sel_rd) begin
        rd_owner <= sel;
        rd_cnt   <= '0;
      end else if (state == ST_RD_WAIT && !bus.i_rd_valid && !timeout_hit) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // A response in the timeout cycle takes precedence over the error.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      rd_valid_q   <= '0;
      rd_err_q     <= '0;
      rd_data_q[0] <= '0;
      rd_data_q[1] <= '0;
    end else begin
      rd_valid_q <= '0;
      rd_err_q   <= '0;
      if (state == ST_RD_WAIT) begin
        if (bus.i_rd_valid) begin
          rd_valid_q[rd_owner] <= 1'b1;
          rd_data_q[rd_owner]  <= bus.i_rd_data;
        end else if (timeout_hit) begin
          rd_valid_q[rd_owner] <= 1'b1;
          rd_err_q[rd_owner]   <= 1'b1;
          rd_data_q[rd_owner]  <= '0;
        end
      end
    end
  end

  assign bus.o_valid        = sel_valid;
  assign bus.o_rd0_wr1      = sel_dir;
  assign bus.o_addr         = sel_addr;
  assign bus.o_wr_data      = sel_wdata;
  assign bus.o_rq0_ready    = xfer && (sel == 1'b0);
  assign bus.o_rq1_ready    = xfer && (sel == 1'b1);
  assign bus.o_rq0_rd_valid = rd_valid_q[0];
  assign bus.o_rq1_rd_valid = rd_valid_q[1];
  assign bus.o_rq0_rd_err   = rd_err_q[0];
  assign bus.o_rq1_rd_err   = rd_err_q[1];
  assign bus.o_rq0_rd_data  = rd_data_q[0];
  assign bus.o_rq1_rd_data  = rd_data_q[1];
  assign bus.o_busy         = (state == ST_RD_WAIT);
  assign bus.o_sleep_ack    = (state == ST_SLEEP);

endmodule

`default_nettype wire

// File: tb/tb_bridge_req_arbiter.sv
// Directed and randomized checks of bridge_req_arbiter against a cycle-level behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_bridge_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bridge_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bridge_req_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_TIMEOUT (TO),
    .CNT_WIDTH  (8)
  ) dut (
    .i_clk_src  (clk),
    .i_rstn_src (rstn),
    .bus        (bus)
  );

  logic          rv [2];
  logic          rw [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];

  assign bus.i_rq0_valid   = rv[0];
  assign bus.i_rq0_rd0_wr1 = rw[0];
  assign bus.i_rq0_addr    = ra[0];
  assign bus.i_rq0_wr_data = rd[0];
  assign bus.i_rq1_valid   = rv[1];
  assign bus.i_rq1_rd0_wr1 = rw[1];
  assign bus.i_rq1_addr    = ra[1];
  assign bus.i_rq1_wr_data = rd[1];

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: transaction-level view of who may be granted and what comes back.
  bit            m_sleep;
  int            m_owner;
  int            m_wait;
  int            m_last;
  bit            e_rdv [2];
  bit            e_err [2];
  logic [DW-1:0] e_rdd [2];
  int            cand;
  bit            e_xfer;
  bit            got_ready [2];

  // Snapshots of DUT outputs taken at the check point of the latest cycle.
  logic          s_valid, s_ready0, s_ready1, s_rdv0, s_rdv1, s_err0, s_ack;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rdd0, s_rdd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sleep = 0;
    m_owner = -1;
    m_wait  = 0;
    m_last  = 1;
    for (int k = 0; k < 2; k++) begin
      e_rdv[k] = 0;
      e_err[k] = 0;
      e_rdd[k] = '0;
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rw[k] = 0; ra[k] = '0; rd[k] = '0;
    end
    bus.i_sleep_req = 0;
    bus.i_ready     = 0;
    bus.i_rd_valid  = 0;
    bus.i_rd_data   = '0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic          e_dir;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #1;
    s_valid  = bus.o_valid;   s_addr   = bus.o_addr;
    s_ready0 = bus.o_rq0_ready; s_ready1 = bus.o_rq1_ready;
    s_rdv0   = bus.o_rq0_rd_valid; s_rdv1 = bus.o_rq1_rd_valid;
    s_err0   = bus.o_rq0_rd_err;   s_ack  = bus.o_sleep_ack;
    s_rdd0   = bus.o_rq0_rd_data;  s_rdd1 = bus.o_rq1_rd_data;

    cand = -1;
    if (!m_sleep && m_owner < 0 && !bus.i_sleep_req) begin
      if (rv[0] && rv[1]) cand = 1 - m_last;
      else if (rv[0])     cand = 0;
      else if (rv[1])     cand = 1;
    end
    e_xfer = (cand >= 0) && bus.i_ready;
    if (cand >= 0) begin
      e_dir = rw[cand]; e_addr = ra[cand]; e_wd = rd[cand];
    end else begin
      e_dir = 0; e_addr = '0; e_wd = '0;
    end

    check("o_valid",    bus.o_valid,    cand >= 0);
    check("o_rd0_wr1",  bus.o_rd0_wr1,  e_dir);
    check("o_addr",     bus.o_addr,     e_addr);
    check("o_wr_data",  bus.o_wr_data,  e_wd);
    check("rq0_ready",  bus.o_rq0_ready, e_xfer && cand == 0);
    check("rq1_ready",  bus.o_rq1_ready, e_xfer && cand == 1);
    check("busy",       bus.o_busy,      m_owner >= 0);
    check("sleep_ack",  bus.o_sleep_ack, m_sleep);
    check("rq0_rd_valid", bus.o_rq0_rd_valid, e_rdv[0]);
    check("rq1_rd_valid", bus.o_rq1_rd_valid, e_rdv[1]);
    check("rq0_rd_err",   bus.o_rq0_rd_err,   e_err[0]);
    check("rq1_rd_err",   bus.o_rq1_rd_err,   e_err[1]);
    check("rq0_rd_data",  bus.o_rq0_rd_data,  e_rdd[0]);
    check("rq1_rd_data",  bus.o_rq1_rd_data,  e_rdd[1]);

    for (int k = 0; k < 2; k++) begin
      e_rdv[k] = 0;
      e_err[k] = 0;
      got_ready[k] = e_xfer && (cand == k);
    end
    if (m_sleep) begin
      if (!bus.i_sleep_req) m_sleep = 0;
    end else if (m_owner >= 0) begin
      if (bus.i_rd_valid) begin
        e_rdv[m_owner] = 1;
        e_rdd[m_owner] = bus.i_rd_data;
        m_owner = -1;
      end else if (TO != 0 && m_wait == TO) begin
        e_rdv[m_owner] = 1;
        e_err[m_owner] = 1;
        e_rdd[m_owner] = '0;
        m_owner = -1;
      end else begin
        m_wait++;
      end
    end else if (bus.i_sleep_req) begin
      m_sleep = 1;
    end else if (e_xfer) begin
      m_last = cand;
      if (!rw[cand]) begin
        m_owner = cand;
        m_wait  = 0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) if (got_ready[k]) rv[k] = 0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rstn = 0;
    #1;
    check({tag, "_o_valid"},   bus.o_valid,        1'b0);
    check({tag, "_busy"},      bus.o_busy,         1'b0);
    check({tag, "_sleep_ack"}, bus.o_sleep_ack,    1'b0);
    check({tag, "_rq0_rdv"},   bus.o_rq0_rd_valid, 1'b0);
    check({tag, "_rq1_rdv"},   bus.o_rq1_rd_valid, 1'b0);
    check({tag, "_rq0_rdd"},   bus.o_rq0_rd_data,  32'h0);
    check({tag, "_rq1_rdd"},   bus.o_rq1_rd_data,  32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic set_rq(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rv[k] = 1; rw[k] = wr; ra[k] = a; rd[k] = d;
  endtask

  int n;

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Both requesters writing back to back: grants alternate starting with rq0.
    bus.i_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (!rv[0]) set_rq(0, 1, 32'h100 + i, 32'hA0 + i);
      if (!rv[1]) set_rq(1, 1, 32'h200 + i, 32'hB0 + i);
      cycle();
      check("alt_grant", s_ready1 ? 2'd1 : (s_ready0 ? 2'd0 : 2'd2), 2'(i % 2));
    end
    rv[0] = 0; rv[1] = 0;
    cycle();

    // Single write from rq0.
    set_rq(0, 1, 32'h10, 32'hAA);
    cycle();
    check("t1_addr",  s_addr,   32'h10);
    check("t1_ready", s_ready0, 1'b1);

    // rq1 read answered after three cycles while rq0 waits.
    set_rq(1, 0, 32'h20, 32'h0);
    cycle();
    set_rq(0, 1, 32'h30, 32'h55);
    cycle();
    cycle();
    bus.i_rd_valid = 1; bus.i_rd_data = 32'h1234;
    cycle();
    bus.i_rd_valid = 0;
    cycle();
    check("t3_rq1_rdv",  s_rdv1, 1'b1);
    check("t3_rq1_rdd",  s_rdd1, 32'h1234);
    check("t3_rq0_rdv",  s_rdv0, 1'b0);
    check("t3_rq0_ready", s_ready0, 1'b1);
    cycle();

    // rq0 read with no response: timeout error, then a late response is dropped.
    set_rq(0, 0, 32'h40, 32'h0);
    cycle();
    n = 0;
    do begin
      cycle();
      n++;
    end while (!s_rdv0 && n < 20);
    check("t4_latency", n, 6);
    check("t4_err",     s_err0, 1'b1);
    check("t4_data",    s_rdd0, 32'h0);
    bus.i_rd_valid = 1; bus.i_rd_data = 32'hDEAD;
    cycle();
    bus.i_rd_valid = 0;
    cycle();
    check("t4_stale", s_rdv0, 1'b0);

    // Sleep raised with a pending request.
    set_rq(0, 1, 32'h50, 32'h11);
    bus.i_sleep_req = 1;
    cycle();
    check("t5_no_valid", s_valid, 1'b0);
    cycle();
    check("t5_ack", s_ack, 1'b1);
    bus.i_sleep_req = 0;
    cycle();
    cycle();
    check("t5_ack_drop", s_ack, 1'b0);
    check("t5_grant",    s_ready0, 1'b1);

    // Sleep during a read is honoured only after the response.
    set_rq(1, 0, 32'h60, 32'h0);
    cycle();
    bus.i_sleep_req = 1;
    cycle();
    cycle();
    bus.i_rd_valid = 1; bus.i_rd_data = 32'h7777;
    cycle();
    bus.i_rd_valid = 0;
    cycle();
    cycle();
    check("t5_ack_after_rd", s_ack, 1'b1);
    bus.i_sleep_req = 0;
    cycle();
    cycle();

    // Reset in the middle of a read; the stale response must not pulse.
    set_rq(0, 0, 32'h70, 32'h0);
    cycle();
    cycle();
    do_reset("t6_reset");
    bus.i_rd_valid = 1; bus.i_rd_data = 32'hBEEF;
    cycle();
    bus.i_rd_valid = 0;
    cycle();
    check("t6_stale", s_rdv0, 1'b0);
    bus.i_ready = 1;
    set_rq(0, 1, 32'h80, 32'h1);
    set_rq(1, 1, 32'h90, 32'h2);
    cycle();
    check("t6_first_grant", s_ready0, 1'b1);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset("rnd_reset");
      for (int k = 0; k < 2; k++) begin
        if (!rv[k] && ($urandom % 3 == 0))
          set_rq(k, 1'($urandom % 2), $urandom, $urandom);
      end
      bus.i_ready    = ($urandom % 4) != 0;
      bus.i_rd_valid = ($urandom % 5) == 0;
      bus.i_rd_data  = $urandom;
      if ($urandom % 20 == 0) bus.i_sleep_req = !bus.i_sleep_req;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bridge_req_arbiter.md
Name: bridge_req_arbiter

Overview:
- Round-robin arbiter that shares the source-side slave interface of the AHB2AHB bridge between two requesters (rq0, rq1).
- Sits in the source clock domain, upstream of the source controller. Forwards one request at a time.
- Allows only one outstanding read and returns each read response to the requester that issued it.
- Adds a read-response timeout and a sleep handshake that blocks new grants.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
RD_TIMEOUT, 255, cycles in RD_WAIT before an error response; 0 disables the timeout
CNT_WIDTH, 8, timeout counter width; must satisfy RD_TIMEOUT < 2^CNT_WIDTH

Ports:
i_clk_src  in  1  source clock
i_rstn_src  in  1  asynchronous, active-low reset
i_sleep_req  in  1  sleep request
o_sleep_ack  out  1  high while in SLEEP
o_busy  out  1  high while in RD_WAIT
i_rqN_valid  in  1  request valid (N = 0, 1 for every rqN port)
i_rqN_rd0_wr1  in  1  0 = read, 1 = write
i_rqN_addr  in  ADDR_WIDTH  address
i_rqN_wr_data  in  DATA_WIDTH  write data
o_rqN_ready  out  1  request accepted this cycle (combinational)
o_rqN_rd_data  out  DATA_WIDTH  read data (registered)
o_rqN_rd_valid  out  1  one-cycle read response pulse
o_rqN_rd_err  out  1  qualifies rd_valid: timeout error
o_valid  out  1  to bridge: request valid
o_rd0_wr1  out  1  to bridge: direction
o_addr  out  ADDR_WIDTH  to bridge: address
o_wr_data  out  DATA_WIDTH  to bridge: write data
i_ready  in  1  from bridge: request accepted
i_rd_data  in  DATA_WIDTH  from bridge: read data
i_rd_valid  in  1  from bridge: read response valid

Behaviour:
Reset:
- State ARB, last_grant = 1 (so rq0 wins the first conflict), rd_owner = 0, counter = 0.
- All registered outputs are 0.

Selection (ARB state only):
- If exactly one requester is valid, it is selected.
- If both are valid, select the one not equal to last_grant.
- o_valid/o_rd0_wr1/o_addr/o_wr_data carry the selected requester's signals combinationally. All are 0 when nothing is selected.

Transfer and ready:
- A transfer occurs when o_valid && i_ready.
- In that same cycle, o_rqSEL_ready = 1 and last_grant <= SEL.
- The non-selected requester's ready is always 0.

State ARB:
- i_sleep_req = 1 → SLEEP. No selection that cycle and o_valid = 0; sleep has priority over pending requests.
- Write transfer → stay in ARB. Back-to-back writes are allowed, and the arbiter alternates when both requesters are valid.
- Read transfer → RD_WAIT, with rd_owner <= SEL and counter <= 0.
- i_rd_valid while in ARB (late or stray response) is dropped. No output pulse.

State RD_WAIT:
- o_valid = 0, both readies = 0, o_busy = 1. i_sleep_req is ignored until the read completes.
- i_rd_valid = 1 → next cycle o_rq[rd_owner]_rd_data = i_rd_data and rd_valid = 1 (one-cycle latency). State → ARB.
- Else if RD_TIMEOUT != 0 and counter == RD_TIMEOUT → next cycle rd_valid = 1, rd_err = 1, rd_data = 0 to rd_owner. State → ARB.
- Else counter increments.
- i_rd_valid in the same cycle as the timeout: the response wins and no error is flagged.

State SLEEP:
- o_sleep_ack = 1, o_valid = 0, readies = 0.
- i_sleep_req = 0 → ARB. o_sleep_ack drops the cycle after request deassertion, because it is decoded from state.

Pulses and data hold:
- rd_valid/rd_err are single-cycle pulses.
- rd_data holds its last value until the next response to that requester.

Mid-operation reset:
- Reset asserted mid-operation (including in RD_WAIT) returns to reset values immediately.
- The outstanding read is abandoned. Its later response arrives in ARB and is dropped.

Requester rule:
- A requester must hold valid and its fields stable until it sees ready. The arbiter never grants a requester whose valid is low.

Decomposition:
- Shared package holds: state encodings (ARB = 2'b00, RD_WAIT = 2'b01, SLEEP = 2'b10), packet-field widths, the requester-index constant.
- One natural sub-module: rr_arb2. It is a 2-way round-robin picker with inputs req[1:0], last_grant and outputs sel, any.
- Everything else (FSM, timeout counter, response routing) stays in bridge_req_arbiter.

Test Plan:
1. rq0 write A=0x10, D=0xAA, i_ready = 1 → o_valid/o_addr = 0x10 the same cycle, o_rq0_ready = 1, state stays ARB.
2. rq0 and rq1 both writing continuously, i_ready = 1 → grants alternate 0, 1, 0, 1 starting with rq0 after reset.
3. rq1 read A=0x20; i_rd_valid = 1 with i_rd_data = 0x1234 three cycles later → o_rq1_rd_valid pulses one cycle later with 0x1234, rq0 sees no pulse, rq0 is blocked during RD_WAIT.
4. RD_TIMEOUT = 4; rq0 read with no response → o_rq0_rd_valid = 1 and o_rq0_rd_err = 1 with data 0. A response arriving after that is dropped.
5. i_sleep_req raised together with rq0 valid → no transfer, o_sleep_ack = 1 next cycle. Deassert → ack drops and rq0 is then granted. A sleep request raised during RD_WAIT is honoured only after the response.
6. Reset asserted in RD_WAIT → all outputs 0, state ARB, last_grant = 1. The stale i_rd_valid produces no pulse.
